// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared FSM type, default widths and index sizing for the folded FIR controller
package fir_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;
    localparam int DEF_DATA_IN_WIDTH = 16;
    localparam int DEF_DATA_OUT_WIDTH = 64;
    localparam int DEF_TAP_WIDTH = 32;
    localparam int DEF_TAP_COUNT = 34;
    localparam int PROD_WIDTH = DEF_DATA_IN_WIDTH + DEF_TAP_WIDTH;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: shared signed multiply-accumulate stage with wrap-around accumulation
module fir_mac_unit
    import fir_ctrl_pkg::*;
#(
    parameter int IN_W = DEF_DATA_IN_WIDTH,
    parameter int TAP_W = DEF_TAP_WIDTH,
    parameter int OUT_W = DEF_DATA_OUT_WIDTH,
    parameter int PROD_W = PROD_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic signed [IN_W-1:0]  sample_i,
    input  logic signed [TAP_W-1:0] coef_i,
    output logic signed [OUT_W-1:0] acc_o
);
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0] acc_q, acc_d;

    always_comb begin
        prod = PROD_W'(sample_i) * PROD_W'(coef_i);
        acc_d = clear_i ? '0 : enable_i ? acc_q + OUT_W'(prod) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: folded FIR that steps one shared MAC over all taps per input sample
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int TAP_WIDTH = DEF_TAP_WIDTH,
    parameter int TAP_COUNT = DEF_TAP_COUNT,
    localparam int IW = idx_width(TAP_COUNT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]  in_data,
    input  logic                             coef_we,
    input  logic [IW-1:0]                    coef_addr,
    input  logic signed [TAP_WIDTH-1:0]      coef_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [DATA_OUT_WIDTH-1:0] out_data,
    output logic                             busy
);
    localparam logic [IW-1:0] LAST = IW'(TAP_COUNT - 1);

    fir_state_t state_q, state_d;
    logic [IW-1:0] k_q, k_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic signed [DATA_IN_WIDTH-1:0] samp_q [TAP_COUNT];
    logic signed [TAP_WIDTH-1:0] coef_q [TAP_COUNT];
    logic accept, handshake, coef_wr, mac_en;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? MAC : IDLE;
            MAC:     state_d = (k_q == LAST) ? DONE : MAC;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state_q == IDLE;
        busy = state_q != IDLE;
        out_valid = state_q == DONE;
        mac_en = state_q == MAC;
    end

    assign accept = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign coef_wr = coef_we && in_ready && (32'(coef_addr) < TAP_COUNT);

    // rd_ptr walks backwards from the newest sample so no modulo is needed per tap
    always_comb begin
        k_d = accept ? '0 : (mac_en && k_q != LAST) ? k_q + 1'b1 : k_q;
        rd_ptr_d = accept ? wr_ptr_q : !mac_en ? rd_ptr_q : (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
        wr_ptr_d = !handshake ? wr_ptr_q : (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < TAP_COUNT; i++) begin
                samp_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            k_q <= k_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (accept)
                samp_q[wr_ptr_q] <= in_data;
            if (coef_wr)
                coef_q[coef_addr] <= coef_data;
        end
    end

    fir_mac_unit #(
        .IN_W(DATA_IN_WIDTH),
        .TAP_W(TAP_WIDTH),
        .OUT_W(DATA_OUT_WIDTH),
        .PROD_W(DATA_IN_WIDTH + TAP_WIDTH)
    ) u_mac (
        .clk(clk),
        .reset(reset),
        .clear_i(accept),
        .enable_i(mac_en),
        .sample_i(samp_q[rd_ptr_q]),
        .coef_i(coef_q[k_q]),
        .acc_o(out_data)
    );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench comparing filter outputs against a direct-form reference sum
module tb_fir_mac_sequencer;
    localparam int N = 34;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] in_data = '0;
    logic coef_we = 1'b0;
    logic [5:0] coef_addr = '0;
    logic signed [31:0] coef_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [63:0] out_data;
    logic busy;

    int n_checks = 0;
    int n_fail = 0;
    longint coef_m [N];
    longint hist [$];
    logic [63:0] exp_q [$];
    logic [63:0] exp_v;

    fir_mac_sequencer dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_out();
        longint s = 0;
        for (int k = 0; k < N && k < hist.size(); k++)
            s += coef_m[k] * hist[k];
        return s;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_out", {63'd0, out_valid}, 64'd0);
            else begin
                exp_v = exp_q.pop_front();
                check("out_data", out_data, exp_v);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        exp_q.delete();
        hist.delete();
        for (int i = 0; i < N; i++) coef_m[i] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic write_coef(input logic [5:0] a, input logic signed [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) check("coef_idle_timeout", {63'd0, in_ready}, 64'd1);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = d;
        if (a < N) coef_m[a] = longint'(d);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] x, input bit cw, input logic [5:0] ca, input logic signed [31:0] cd);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data = x;
        coef_we = cw;
        coef_addr = ca;
        coef_data = cd;
        if (cw && ca < N) coef_m[ca] = longint'(cd);
        hist.push_front(longint'(x));
        if (hist.size() > N) void'(hist.pop_back());
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [63:0] held;
        do_reset();
        check_reset_state();

        // impulse response with coef[k] = k+1, plus an out-of-range write that must be dropped
        for (int k = 0; k < N; k++) write_coef(6'(k), 32'(k + 1));
        write_coef(6'd40, 32'sd12345);
        send(16'sd1, 1'b0, 6'd0, 32'sd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("mac_busy", {63'd0, busy}, 64'd1);
            if (n == 1) check("mac_in_ready", {63'd0, in_ready}, 64'd0);
        end while (!out_valid && n < 60);
        check("latency", 64'(n), 64'd35);
        for (int i = 0; i < N + 1; i++) send(16'sd0, 1'b0, 6'd0, 32'sd0);
        drain();

        // step response with negative taps
        for (int k = 0; k < N; k++) write_coef(6'(k), -32'sd3);
        for (int i = 0; i < N + 2; i++) send(16'sd100, 1'b0, 6'd0, 32'sd0);
        drain();

        // backpressure: result held in DONE while a new sample waits on the input
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(-16'sd1234, 1'b0, 6'd0, 32'sd0);
        n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        held = out_data;
        in_valid = 1'b1;
        in_data = 16'sd555;
        repeat (10) begin
            @(negedge clk);
            check("bp_stable", out_data, held);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_busy", {63'd0, busy}, 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'sd555, 1'b0, 6'd0, 32'sd0);
        drain();

        // coefficient write during MAC is ignored; alongside an accept it applies
        send(16'sd50, 1'b0, 6'd0, 32'sd0);
        coef_we = 1'b1;
        coef_addr = 6'd0;
        coef_data = 32'sd7;
        repeat (5) @(posedge clk);
        #1 coef_we = 1'b0;
        drain();
        send(16'sd60, 1'b1, 6'd0, 32'sd7);
        drain();

        // reset in the middle of MAC discards the pending result
        send(16'sd77, 1'b0, 6'd0, 32'sd0);
        repeat (9) @(posedge clk);
        #1 do_reset();
        cnt = 0;
        repeat (50) begin @(negedge clk); if (out_valid) cnt++; end
        check("rst_no_valid", 64'(cnt), 64'd0);
        check_reset_state();
        send(16'sd1, 1'b0, 6'd0, 32'sd0);
        send(-16'sd5, 1'b0, 6'd0, 32'sd0);
        drain();

        // extremes: most negative coefficients and samples
        for (int k = 0; k < N; k++) write_coef(6'(k), 32'sh80000000);
        for (int i = 0; i < 40; i++) send(16'sh8000, 1'b0, 6'd0, 32'sd0);
        drain();

        // random data across several buffer wraps
        for (int k = 0; k < N; k++) write_coef(6'(k), 32'($urandom));
        for (int i = 0; i < 40; i++) send(16'($urandom), 1'b0, 6'd0, 32'sd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Folded (time-multiplexed) FIR controller: a single shared multiply-accumulate unit is stepped over TAP_COUNT taps per input sample, instead of TAP_COUNT parallel multipliers.
- Owns a circular sample buffer, a programmable coefficient store, and a valid/ready handshake on input and output.
- Sits between the sample source and the downstream consumer, as the low-area alternative to the fully parallel FIR datapath.

Parameters:
- DATA_IN_WIDTH, 16, signed input sample width
- DATA_OUT_WIDTH, 64, signed accumulator/output width; must be >= DATA_IN_WIDTH+TAP_WIDTH
- TAP_WIDTH, 32, signed coefficient width
- TAP_COUNT, 34, number of taps; must be >= 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_IN_WIDTH  signed sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAP_COUNT)  coefficient index
- coef_data  in  TAP_WIDTH  signed coefficient
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_OUT_WIDTH  signed filter output
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface (decided): one clock, clk. Reset is synchronous and active-high, port reset.
- Reset:
  - state=IDLE; out_valid=0; out_data=0; busy=0; in_ready=1 after reset deasserts.
  - Accumulator, tap index, write pointer, all sample buffer entries and all coefficients cleared to 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready (cycle t): write in_data to buf[wr_ptr], clear acc, k=0, go to MAC.
  - MAC: one tap per cycle. acc += sext(coef[k]*buf[(wr_ptr-k) mod TAP_COUNT]); k++. After k=TAP_COUNT-1 is processed, go to DONE.
  - DONE: out_valid=1, out_data=acc, both held stable until out_ready. On out_valid&&out_ready: wr_ptr=(wr_ptr+1) mod TAP_COUNT, out_valid=0 next cycle, go to IDLE.
- Timing:
  - MAC occupies cycles t+1..t+TAP_COUNT. out_valid first high in cycle t+TAP_COUNT+1.
  - Minimum sample period is TAP_COUNT+2 cycles.
- Result: out_data = sum over k=0..TAP_COUNT-1 of coef[k]*x[n-k]. Samples before reset, or never written, count as 0.
- Arithmetic:
  - Product is a full signed (DATA_IN_WIDTH+TAP_WIDTH)-bit value, sign-extended to DATA_OUT_WIDTH.
  - Accumulation wraps modulo 2^DATA_OUT_WIDTH; no saturation.
- Coefficient writes:
  - Honoured only in IDLE; ignored in MAC/DONE. coef_addr >= TAP_COUNT is ignored.
  - If coef_we and a sample accept occur in the same IDLE cycle, both take effect, and that sample's MAC uses the new coefficient.
- Wrap-around: pointer arithmetic is modulo TAP_COUNT and must be correct for non-power-of-2 TAP_COUNT.
- in_valid outside IDLE: ignored, in_ready=0; the source must hold the sample.
- Reset mid-MAC or mid-DONE: abort immediately; any pending result is discarded and never presented; all state returns to reset values.
- out_ready high while out_valid is low: no effect.

Decomposition:
- Package fir_ctrl_pkg:
  - enum fir_state_t {IDLE, MAC, DONE}.
  - Function for pointer/index width, clog2(TAP_COUNT).
  - Localparam PROD_WIDTH = DATA_IN_WIDTH+TAP_WIDTH.
- Sub-module fir_mac_unit:
  - Inputs: clear, enable, sample, coef.
  - Output: registered acc.
  - Behaviour: signed multiply, sign-extend, wrap-add.
  - Instantiated once, driven by the FSM.

Test Plan:
- Impulse response: load coef[k]=k+1; feed 1 then 34 zeros, out_ready=1 -> outputs 1,2,...,34, then 0. First out_valid exactly 35 cycles after the accept.
- Step with negatives: coef[k]=-3 for all k; feed in_data=100 repeatedly -> outputs -300, -600, ..., then -10200 steady from the 34th output onward.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, busy=1. The next sample is accepted only after the handshake, and wr_ptr advances exactly once.
- Coefficient write while busy: coef_we with addr 0, data 7 during MAC -> ignored, result unchanged. Same write in IDLE alongside a sample accept -> that sample's output uses coef[0]=7.
- Reset mid-MAC: assert reset at MAC cycle 10 -> out_valid never asserts for that sample. Post-reset, an impulse with all-zero coefficients gives 0.
- Extremes/wrap: all coef = -2^31, samples = -2^15, run 40 samples -> each output equals the modulo-2^64 sum from the reference model. Check that wr_ptr wraps 33->0 correctly.
